// File: rtl/capture_gate_sequencer_if.sv
// ADC-in / filter-out AXI4-Stream bundle for capture_gate_sequencer.
// gate_tlast is present only when CAPSEQ_TLAST_EN is defined.
interface capture_gate_sequencer_if #(
  parameter int NCHAN = 2
);
  logic [NCHAN*128-1:0] adc_tdata;
  logic [NCHAN-1:0]     adc_tvalid;
  logic [NCHAN-1:0]     adc_tready;
  logic [NCHAN*128-1:0] gate_tdata;
  logic [NCHAN-1:0]     gate_tvalid;
  logic [NCHAN-1:0]     gate_tready;
`ifdef CAPSEQ_TLAST_EN
  logic [NCHAN-1:0]     gate_tlast;
`endif

  // master: stream environment (ADC source and filter sink); slave: the sequencer
  modport master (
    output adc_tdata, adc_tvalid, gate_tready,
    input  adc_tready, gate_tdata, gate_tvalid
`ifdef CAPSEQ_TLAST_EN
    , gate_tlast
`endif
  );

  modport slave (
    input  adc_tdata, adc_tvalid, gate_tready,
    output adc_tready, gate_tdata, gate_tvalid
`ifdef CAPSEQ_TLAST_EN
    , gate_tlast
`endif
  );
endinterface

// File: rtl/capture_gate_sequencer.sv
// Trigger -> delay -> gate window -> settle -> filter reset sequencer for ADC streams.
// Optional CAPSEQ_TLAST_EN adds gate_tlast framing on the final gated beat.
module capture_gate_lane (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         open_i,
  input  logic [127:0] din_i,
  output logic [127:0] dout_o
);
  logic [127:0] dout_q;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) dout_q <= '0;
    else          dout_q <= open_i ? din_i : '0;

  assign dout_o = dout_q;
endmodule

module capture_gate_sequencer #(
  parameter int NCHAN   = 2,
  parameter int CNTBITS = 16,
  parameter int OVRBITS = 8
)(
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 capture_i,
  input  logic [CNTBITS-1:0]   cfg_delay_i,
  input  logic [CNTBITS-1:0]   cfg_gate_len_i,
  input  logic [CNTBITS-1:0]   cfg_post_i,
  input  logic [CNTBITS-1:0]   cfg_rst_len_i,
  input  logic [NCHAN-1:0]     cfg_chan_mask_i,
  capture_gate_sequencer_if.slave axis,
  output logic                 filt_rst_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [OVRBITS-1:0]   overrun_o
);
  typedef enum logic [2:0] {IDLE, DELAY, GATE, POST, RST} state_e;

  state_e              state_q, state_d;
  logic [CNTBITS-1:0]  cnt_q, cnt_d;
  logic [CNTBITS-1:0]  dly_q, len_q, post_q, rlen_q;
  logic [CNTBITS-1:0]  src_d, src_l, src_p, src_r;
  logic [NCHAN-1:0]    mask_q;
  logic                cap_q, trig, accept;
  logic                filt_q, done_q;
  logic [OVRBITS-1:0]  ovr_q;
  logic [NCHAN-1:0]    tvalid_q;
  logic [NCHAN-1:0]    open;
  logic [NCHAN-1:0][127:0] adc_w, gate_w;
  logic                unused_sink;

  // First state after 'from' whose length is nonzero; IDLE when none remain.
  function automatic state_e next_nz(state_e from, logic [CNTBITS-1:0] d, l, p, r);
    state_e s;
    s = IDLE;
    if (from == IDLE && d != '0)                            s = DELAY;
    else if ((from == IDLE || from == DELAY) && l != '0)    s = GATE;
    else if (from != POST && from != RST && p != '0)       s = POST;
    else if (from != RST && r != '0)                        s = RST;
    return s;
  endfunction

  function automatic logic [CNTBITS-1:0] len_of(state_e st, logic [CNTBITS-1:0] d, l, p, r);
    logic [CNTBITS-1:0] v;
    v = '0;
    case (st)
      DELAY:   v = d;
      GATE:    v = l;
      POST:    v = p;
      RST:     v = r;
      default: v = '0;
    endcase
    return v;
  endfunction

  assign trig   = capture_i & ~cap_q;
  assign accept = trig && (state_q == IDLE);

  // Shadows load on the accepting edge, so the IDLE decision reads cfg directly.
  assign src_d = (state_q == IDLE) ? cfg_delay_i    : dly_q;
  assign src_l = (state_q == IDLE) ? cfg_gate_len_i : len_q;
  assign src_p = (state_q == IDLE) ? cfg_post_i     : post_q;
  assign src_r = (state_q == IDLE) ? cfg_rst_len_i  : rlen_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (trig) begin
        state_d = next_nz(IDLE, src_d, src_l, src_p, src_r);
        cnt_d   = len_of(state_d, src_d, src_l, src_p, src_r);
      end
    end else if (cnt_q == CNTBITS'(1)) begin
      state_d = next_nz(state_q, src_d, src_l, src_p, src_r);
      cnt_d   = len_of(state_d, src_d, src_l, src_p, src_r);
    end else begin
      cnt_d = cnt_q - CNTBITS'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cap_q    <= 1'b1;
      filt_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= '0;
      tvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= capture_i;
      filt_q   <= (state_d == RST);
      done_q   <= (state_d == IDLE) && (state_q != IDLE || trig);
      tvalid_q <= '1;
      if (trig && state_q != IDLE && ovr_q != '1) ovr_q <= ovr_q + OVRBITS'(1);
    end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      dly_q  <= '0;
      len_q  <= '0;
      post_q <= '0;
      rlen_q <= '0;
      mask_q <= '0;
    end else if (accept) begin
      dly_q  <= cfg_delay_i;
      len_q  <= cfg_gate_len_i;
      post_q <= cfg_post_i;
      rlen_q <= cfg_rst_len_i;
      mask_q <= cfg_chan_mask_i;
    end

  assign open  = {NCHAN{state_q == GATE}} & mask_q;
  assign adc_w = axis.adc_tdata;

  for (genvar c = 0; c < NCHAN; c++) begin : g_lane
    capture_gate_lane u_lane (
      .aclk   (aclk),
      .aresetn(aresetn),
      .open_i (open[c]),
      .din_i  (adc_w[c]),
      .dout_o (gate_w[c])
    );
  end

`ifdef CAPSEQ_TLAST_EN
  logic [NCHAN-1:0] tlast_q;
  // Framing ignores the mask so DMA sees a frame end on every channel.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) tlast_q <= '0;
    else          tlast_q <= {NCHAN{state_q == GATE && cnt_q == CNTBITS'(1)}};
  assign axis.gate_tlast = tlast_q;
`endif

  assign axis.gate_tdata  = gate_w;
  assign axis.gate_tvalid = tvalid_q;
  assign axis.adc_tready  = '1;
  assign filt_rst_o       = filt_q;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;
  assign overrun_o        = ovr_q;
  assign unused_sink      = ^{axis.adc_tvalid, axis.gate_tready};
endmodule
